branch_recovery_ctrl: RTL
=========================

# branch_recovery_ctrl

Consumes resolved-branch results from the branch execution unit and turns a mispredict into a backend squash and a front-end redirect. Selects the oldest outstanding mispredict by ROB age, issues a one-cycle flush, holds a redirect to fetch until it is accepted, then holds dispatch stalled for a short drain window. Sits between the branch execution unit outputs and the fetch/ROB/dispatch control inputs.

## Interface
- DATA_WIDTH, 32, PC/target width
- ROB_WIDTH, 4, ROB tag width; ROB depth = 2^ROB_WIDTH
- DRAIN_CYCLES, 2, dispatch-stall cycles after redirect acceptance (>=1)
- CNT_WIDTH, 16, mispredict counter width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_br_valid  in  1  branch result valid this cycle
- i_br_rob_tag  in  ROB_WIDTH  ROB tag of resolved branch
- i_br_mispredict  in  1  branch was mispredicted
- i_br_target_addr  in  DATA_WIDTH  correct next PC
- i_rob_head  in  ROB_WIDTH  tag of oldest ROB entry
- i_fetch_ready  in  1  fetch accepts redirect this cycle
- o_flush  out  1  one-cycle squash pulse
- o_flush_rob_tag  out  ROB_WIDTH  squash all entries strictly younger than this tag
- o_redirect_valid  out  1  redirect request to fetch
- o_redirect_pc  out  DATA_WIDTH  redirect target, bit 0 forced to 0
- o_busy  out  1  recovery in progress; stalls dispatch
- o_mispredict_count  out  CNT_WIDTH  saturating count of accepted mispredicts

## Operation
- Candidate: i_br_valid && i_br_mispredict. Non-mispredict results ignored.
- Age(t) = (t - i_rob_head) mod 2^ROB_WIDTH, ROB_WIDTH-bit wrap subtraction; smaller age = older.
- States: IDLE, FLUSH, REDIRECT, DRAIN.
- IDLE: candidate -> latch tag/target, go FLUSH.
- FLUSH (1 cycle): o_flush=1, o_flush_rob_tag=latched tag; next REDIRECT.
- REDIRECT: o_redirect_valid=1, o_redirect_pc=latched target; on i_fetch_ready go DRAIN, load drain counter with DRAIN_CYCLES.
- DRAIN: counter decrements each cycle; at 1 -> IDLE.
- Preemption in FLUSH/REDIRECT/DRAIN: candidate with Age(new) < Age(latched) replaces latched tag/target and goes to FLUSH next cycle (also preempts a same-cycle fetch handshake). Age equal or greater: ignored (already squashed).
- Counter increments on every accepted candidate (IDLE entry or preemption); saturates at all-ones.
- o_busy = state != IDLE.

## Timing
- Reset: state IDLE; o_flush, o_flush_rob_tag, o_redirect_valid, o_redirect_pc, o_busy, o_mispredict_count, drain counter all 0.
- All outputs registered/state-decoded; no combinational input-to-output paths.
- Candidate at cycle N (IDLE) -> o_flush and o_busy high at N+1 -> o_redirect_valid high from N+2 until the cycle i_fetch_ready is sampled high -> DRAIN for DRAIN_CYCLES cycles -> IDLE, o_busy low.
- Redirect handshake: o_redirect_valid and o_redirect_pc stable while waiting; transfer when both valid and ready high at an edge; o_redirect_valid low next cycle unless preempted.
- Minimum recovery with immediate ready: FLUSH 1 + REDIRECT 1 + DRAIN DRAIN_CYCLES cycles.
- Tag wrap: age compare correct across wrap (head=14, tags 15 and 1: 15 older).
- Reset asserted mid-recovery: immediate return to IDLE, redirect and flush dropped, counter cleared.

## Structure
- Shared package: recovery state enum, rob age function (tag, head) -> age.
- Sub-module rob_age_cmp: combinational, inputs two tags + head, output a_older_than_b; reusable by ROB/LSQ.
- Remainder: one FSM + drain counter + saturating counter in branch_recovery_ctrl.

## Test plan
- Head=0, mispredict tag 3, target 0x100, fetch ready held high -> flush pulse tag 3 at N+1, redirect 0x100 at N+2, busy low at N+5 (DRAIN_CYCLES=2), count 1.
- Correctly-predicted result (mispredict=0) in IDLE -> no flush, busy stays 0, count 0.
- Fetch ready low 4 cycles in REDIRECT -> o_redirect_valid and pc 0x200 held constant 4 cycles, accepted on 5th.
- In REDIRECT latched tag 5, head 2; new mispredict tag 3 target 0x80 -> second flush pulse tag 3, redirect 0x80, count 2; later tag 7 -> ignored.
- Wrap: head 14, latched tag 1, new mispredict tag 15 -> preempts (older); tag 2 -> ignored.
- Assert i_rst_n low during DRAIN and during REDIRECT -> all outputs 0 same cycle, IDLE after release; saturate counter with CNT_WIDTH=2 after 4 mispredicts -> stays 3.

Source files
------------

// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared types and helpers for branch misprediction recovery.
// ROB age is measured as wrap-around distance from the current ROB head.
package branch_recovery_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT,
        ST_DRAIN
    } recovery_state_t;

    // Widest ROB tag the age helper supports; narrower tags are zero-extended.
    localparam int MAX_ROB_WIDTH = 16;

    typedef logic [MAX_ROB_WIDTH-1:0] rob_wide_t;

    // Distance of tag from head, modulo 2^width; smaller means older.
    function automatic rob_wide_t rob_age(
        input rob_wide_t tag,
        input rob_wide_t head,
        input int        width
    );
        rob_wide_t mask;
        mask = rob_wide_t'((32'd1 << width) - 32'd1);
        return (tag - head) & mask;
    endfunction

endpackage

// File: rtl/branch_recovery_ctrl_rob_age_cmp.sv
// Combinational ROB age comparator: is tag_a strictly older than tag_b
// relative to the current head, correct across tag wrap-around.
module rob_age_cmp
    import branch_recovery_ctrl_pkg::*;
#(
    parameter int ROB_WIDTH = 4
) (
    input  logic [ROB_WIDTH-1:0] tag_a,
    input  logic [ROB_WIDTH-1:0] tag_b,
    input  logic [ROB_WIDTH-1:0] head,
    output logic                 a_older_than_b
);

    rob_wide_t a_wide;
    rob_wide_t b_wide;
    rob_wide_t head_wide;
    rob_wide_t age_a;
    rob_wide_t age_b;

    assign a_wide    = rob_wide_t'(tag_a);
    assign b_wide    = rob_wide_t'(tag_b);
    assign head_wide = rob_wide_t'(head);

    assign age_a = rob_age(a_wide, head_wide, ROB_WIDTH);
    assign age_b = rob_age(b_wide, head_wide, ROB_WIDTH);

    assign a_older_than_b = (age_a < age_b);

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Turns the oldest outstanding branch mispredict into a one-cycle flush,
// a held fetch redirect, and a short dispatch-stall drain window.
module branch_recovery_ctrl
    import branch_recovery_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_WIDTH    = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_br_valid,
    input  logic [ROB_WIDTH-1:0]  i_br_rob_tag,
    input  logic                  i_br_mispredict,
    input  logic [DATA_WIDTH-1:0] i_br_target_addr,
    input  logic [ROB_WIDTH-1:0]  i_rob_head,
    input  logic                  i_fetch_ready,
    output logic                  o_flush,
    output logic [ROB_WIDTH-1:0]  o_flush_rob_tag,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] PC_MASK = ~DATA_WIDTH'(1);

    recovery_state_t       state_reg,  state_next;
    logic [ROB_WIDTH-1:0]  tag_reg,    tag_next;
    logic [DATA_WIDTH-1:0] target_reg, target_next;
    logic [DRAIN_W-1:0]    drain_reg,  drain_next;
    logic [CNT_WIDTH-1:0]  count_reg,  count_next;

    logic candidate;
    logic new_is_older;
    logic accept;

    assign candidate = i_br_valid && i_br_mispredict;

    rob_age_cmp #(
        .ROB_WIDTH (ROB_WIDTH)
    ) u_age_cmp (
        .tag_a          (i_br_rob_tag),
        .tag_b          (tag_reg),
        .head           (i_rob_head),
        .a_older_than_b (new_is_older)
    );

    // Equal-or-younger mispredicts are already covered by the pending squash.
    assign accept = candidate && ((state_reg == ST_IDLE) || new_is_older);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= ST_IDLE;
            tag_reg    <= '0;
            target_reg <= '0;
            drain_reg  <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            tag_reg    <= tag_next;
            target_reg <= target_next;
            drain_reg  <= drain_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tag_next    = tag_reg;
        target_next = target_reg;
        drain_next  = drain_reg;
        count_next  = count_reg;

        // A newly accepted mispredict wins over any handshake this cycle.
        if (accept) begin
            state_next  = ST_FLUSH;
            tag_next    = i_br_rob_tag;
            target_next = i_br_target_addr;
            if (count_reg != '1) begin
                count_next = count_reg + CNT_WIDTH'(1);
            end
        end else begin
            case (state_reg)
                ST_FLUSH: begin
                    state_next = ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (i_fetch_ready) begin
                        state_next = ST_DRAIN;
                        drain_next = DRAIN_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    drain_next = drain_reg - DRAIN_W'(1);
                    if (drain_reg <= DRAIN_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign o_flush            = (state_reg == ST_FLUSH);
    assign o_flush_rob_tag    = o_flush ? tag_reg : '0;
    assign o_redirect_valid   = (state_reg == ST_REDIRECT);
    assign o_redirect_pc      = o_redirect_valid ? (target_reg & PC_MASK) : '0;
    assign o_busy             = (state_reg != ST_IDLE);
    assign o_mispredict_count = count_reg;

endmodule
